ahb_arbiter_param: RTL and testbench

//  Parametrised AHB bus arbiter, successor to the fixed 3-master arbiter. Supports N masters,

---
 rtl/ahb_arbiter_param.sv | 180 ++++++++++++++++++
 tb/tb_ahb_arbiter_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB bus arbiter: N masters, fixed-priority or round-robin selection,
// burst-aware grant hold, HLOCK retention and SPLIT masking of the data-phase owner.
module ahb_arbiter_param #(
    parameter int N_MASTER   = 3,
    parameter int W_MASTER   = 2,
    parameter int DEF_MASTER = 0,
    parameter int ARB_MODE   = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [N_MASTER-1:0] HBUSREQ,
    input  logic [N_MASTER-1:0] HLOCK,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HBURST,
    input  logic                HREADY,
    input  logic [1:0]          HRESP,
    input  logic [N_MASTER-1:0] HSPLIT,
    output logic [N_MASTER-1:0] HGRANT,
    output logic [W_MASTER-1:0] HMASTER,
    output logic [W_MASTER-1:0] HMASTER_del,
    output logic                HMASTLOCK
);

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RSP_RETRY  = 2'b10;
    localparam logic [1:0] RSP_SPLIT  = 2'b11;
    localparam logic [2:0] BU_SINGLE  = 3'd0;
    localparam logic [2:0] BU_INCR    = 3'd1;

    localparam logic [W_MASTER-1:0] DEF_IDX   = W_MASTER'(DEF_MASTER);
    localparam logic [N_MASTER-1:0] ONE_N     = {{(N_MASTER-1){1'b0}}, 1'b1};
    localparam logic [N_MASTER-1:0] DEF_GRANT = ONE_N << DEF_MASTER;

    // Remaining beats after the first one for a burst encoding; INCR counts as open-ended.
    function automatic logic [3:0] f_burst_last(input logic [2:0] burst);
        logic [3:0] v;
        case (burst)
            3'd2, 3'd3: v = 4'd3;
            3'd4, 3'd5: v = 4'd7;
            3'd6, 3'd7: v = 4'd15;
            default:    v = 4'd0;
        endcase
        return v;
    endfunction

    function automatic logic [W_MASTER-1:0] f_oh_index(input logic [N_MASTER-1:0] oh);
        logic [W_MASTER-1:0] v;
        v = {W_MASTER{1'b0}};
        for (int i = 0; i < N_MASTER; i++) begin
            v = oh[i] ? (v | W_MASTER'(i)) : v;
        end
        return v;
    endfunction

    function automatic logic [W_MASTER-1:0] f_lowest(input logic [N_MASTER-1:0] vec);
        logic [W_MASTER-1:0] v;
        v = {W_MASTER{1'b0}};
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            v = vec[i] ? W_MASTER'(i) : v;
        end
        return v;
    endfunction

    logic [N_MASTER-1:0] r_grant;
    logic [W_MASTER-1:0] r_hmaster;
    logic [W_MASTER-1:0] r_hmaster_del;
    logic                r_mastlock;
    logic [N_MASTER-1:0] r_mask;
    logic [3:0]          r_beat_cnt;
    logic [W_MASTER-1:0] r_rr_ptr;

    logic [W_MASTER-1:0] w_gnt_idx;
    logic [W_MASTER-1:0] w_sel;
    logic                w_lock_hold;
    logic                w_abort;
    logic                w_last_beat;
    logic                w_incr_release;
    logic                w_xfer_done;
    logic                w_arb_ok;
    logic [N_MASTER-1:0] w_mask_set;
    logic [N_MASTER-1:0] w_mask_nxt;
    logic [N_MASTER-1:0] w_cand;
    logic [N_MASTER-1:0] w_upper;
    logic [N_MASTER-1:0] w_hi_vec;
    logic [N_MASTER-1:0] w_lo_vec;
    logic [N_MASTER-1:0] w_grant_nxt;

    assign w_gnt_idx      = f_oh_index(r_grant);
    assign w_lock_hold    = r_mastlock & HLOCK[r_hmaster];
    assign w_abort        = ~HREADY & ((HRESP == RSP_SPLIT) | (HRESP == RSP_RETRY));
    assign w_last_beat    = (HTRANS == TR_SEQ) & (HBURST[2] | HBURST[1]) & (r_beat_cnt == 4'd1);
    assign w_incr_release = (HBURST == BU_INCR) & ~HBUSREQ[r_hmaster];
    assign w_xfer_done    = (HTRANS == TR_IDLE)
                          | ((HTRANS == TR_NONSEQ) & (HBURST == BU_SINGLE))
                          | w_last_beat
                          | w_incr_release;
    // A retry/split wait cycle must hand the bus over even under a lock.
    assign w_arb_ok       = w_abort | (HREADY & ~w_lock_hold & w_xfer_done);

    // First SPLIT cycle masks the data-phase owner; the park master is never masked.
    always_comb begin
        w_mask_set = {N_MASTER{1'b0}};
        if (!HREADY && (HRESP == RSP_SPLIT) && (r_hmaster_del != DEF_IDX)) begin
            w_mask_set = ONE_N << r_hmaster_del;
        end else begin
            w_mask_set = {N_MASTER{1'b0}};
        end
    end

    assign w_mask_nxt = (r_mask & ~HSPLIT) | w_mask_set;
    // The master being split right now is already excluded from this decision.
    assign w_cand     = HBUSREQ & ~(r_mask | w_mask_set);

    // Priority window: every index in fixed mode, indices above the last grant in RR mode.
    always_comb begin
        w_upper = {N_MASTER{1'b0}};
        for (int i = 0; i < N_MASTER; i++) begin
            w_upper[i] = (ARB_MODE == 0) || (W_MASTER'(i) > r_rr_ptr);
        end
    end

    assign w_hi_vec    = w_cand & w_upper;
    assign w_lo_vec    = w_cand & ~w_upper;
    assign w_sel       = (|w_hi_vec) ? f_lowest(w_hi_vec)
                       : (|w_lo_vec) ? f_lowest(w_lo_vec)
                       : DEF_IDX;
    assign w_grant_nxt = ONE_N << w_sel;

    // Grant and round-robin pointer move only at arbitration points.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant  <= DEF_GRANT;
            r_rr_ptr <= DEF_IDX;
        end else if (w_arb_ok) begin
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_sel;
        end
    end

    // Address/data-phase ownership advances with each completed transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hmaster     <= DEF_IDX;
            r_hmaster_del <= DEF_IDX;
            r_mastlock    <= 1'b0;
        end else if (HREADY) begin
            r_hmaster     <= w_gnt_idx;
            r_mastlock    <= HLOCK[w_gnt_idx];
            r_hmaster_del <= r_hmaster;
        end
    end

    // Beat counter tracks how far into a fixed-length burst the owner is.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_beat_cnt <= 4'd0;
        end else if (HREADY && (HTRANS == TR_NONSEQ)) begin
            r_beat_cnt <= f_burst_last(HBURST);
        end else if (HREADY && (HTRANS == TR_SEQ) && (r_beat_cnt != 4'd0)) begin
            r_beat_cnt <= r_beat_cnt - 4'd1;
        end
    end

    // Split mask: set wins over a same-cycle unsplit pulse.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mask <= {N_MASTER{1'b0}};
        end else begin
            r_mask <= w_mask_nxt;
        end
    end

    assign HGRANT      = r_grant;
    assign HMASTER     = r_hmaster;
    assign HMASTER_del = r_hmaster_del;
    assign HMASTLOCK   = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Bench for ahb_arbiter_param: fixed-priority and round-robin instances driven in parallel,
// directed scenarios plus random traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_ahb_arbiter_param;
    localparam int N   = 3;
    localparam int W   = 2;
    localparam int DEF = 0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] hbusreq, hlock, hsplit;
    logic [1:0]   htrans, hresp;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] gnt_fp, gnt_rr;
    logic [W-1:0] mst_fp, mst_rr, del_fp, del_rr;
    logic         mlk_fp, mlk_rr;

    always #5 clk = ~clk;

    ahb_arbiter_param #(.N_MASTER(N), .W_MASTER(W), .DEF_MASTER(DEF), .ARB_MODE(0)) u_dut_fp (
        .HCLK(clk), .HRESETn(rst_n), .HBUSREQ(hbusreq), .HLOCK(hlock), .HTRANS(htrans),
        .HBURST(hburst), .HREADY(hready), .HRESP(hresp), .HSPLIT(hsplit),
        .HGRANT(gnt_fp), .HMASTER(mst_fp), .HMASTER_del(del_fp), .HMASTLOCK(mlk_fp));

    ahb_arbiter_param #(.N_MASTER(N), .W_MASTER(W), .DEF_MASTER(DEF), .ARB_MODE(1)) u_dut_rr (
        .HCLK(clk), .HRESETn(rst_n), .HBUSREQ(hbusreq), .HLOCK(hlock), .HTRANS(htrans),
        .HBURST(hburst), .HREADY(hready), .HRESP(hresp), .HSPLIT(hsplit),
        .HGRANT(gnt_rr), .HMASTER(mst_rr), .HMASTER_del(del_rr), .HMASTLOCK(mlk_rr));

    int n_total = 0;
    int n_bad   = 0;

    // Reference state, index 0 = fixed priority, index 1 = round robin.
    int           m_gnt[2], m_mst[2], m_del[2], m_ptr[2];
    bit           m_lck[2];
    bit [N-1:0]   m_mask[2];
    int           m_len, m_beat;
    int           len_tab[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int md = 0; md < 2; md++) begin
            m_gnt[md]  = DEF;
            m_mst[md]  = DEF;
            m_del[md]  = DEF;
            m_ptr[md]  = DEF;
            m_lck[md]  = 1'b0;
            m_mask[md] = '0;
        end
        m_len  = 1;
        m_beat = 1;
    endtask

    // One clock edge of the arbitration rules, applied to the current inputs.
    task automatic model_step();
        for (int md = 0; md < 2; md++) begin
            bit         arb, abort, held, done, ended, split_now;
            bit [N-1:0] blocked, cand, nmask;
            int         win;
            abort = !hready && (hresp == 2'b10 || hresp == 2'b11);
            held  = m_lck[md] && hlock[m_mst[md]];
            ended = (hburst >= 3'd2) && (htrans == 2'b11) && (m_beat + 1 == m_len);
            done  = (htrans == 2'b00) || (htrans == 2'b10 && hburst == 3'd0) || ended
                    || (hburst == 3'd1 && !hbusreq[m_mst[md]]);
            arb   = abort || (hready && !held && done);
            split_now = !hready && hresp == 2'b11 && m_del[md] != DEF;
            blocked = m_mask[md];
            if (split_now) blocked[m_del[md]] = 1'b1;
            cand = hbusreq & ~blocked;
            win  = -1;
            if (md == 0) begin
                for (int i = 0; i < N; i++) if (cand[i] && win < 0) win = i;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int idx = (m_ptr[md] + k) % N;
                    if (cand[idx] && win < 0) win = idx;
                end
            end
            if (win < 0) win = DEF;
            nmask = m_mask[md] & ~hsplit;
            if (split_now) nmask[m_del[md]] = 1'b1;
            m_mask[md] = nmask;
            if (hready) begin
                m_lck[md] = hlock[m_gnt[md]];
                m_del[md] = m_mst[md];
                m_mst[md] = m_gnt[md];
            end
            if (arb) begin
                m_gnt[md] = win;
                m_ptr[md] = win;
            end
        end
        if (hready && htrans == 2'b10) begin
            m_len  = len_tab[hburst];
            m_beat = 1;
        end else if (hready && htrans == 2'b11) begin
            m_beat++;
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, "/gnt_fp"}, 32'(gnt_fp), 32'(1 << m_gnt[0]));
        check_eq({ph, "/gnt_rr"}, 32'(gnt_rr), 32'(1 << m_gnt[1]));
        check_eq({ph, "/mst_fp"}, 32'(mst_fp), 32'(m_mst[0]));
        check_eq({ph, "/mst_rr"}, 32'(mst_rr), 32'(m_mst[1]));
        check_eq({ph, "/del_fp"}, 32'(del_fp), 32'(m_del[0]));
        check_eq({ph, "/del_rr"}, 32'(del_rr), 32'(m_del[1]));
        check_eq({ph, "/lck_fp"}, 32'(mlk_fp), 32'(m_lck[0]));
        check_eq({ph, "/lck_rr"}, 32'(mlk_rr), 32'(m_lck[1]));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(ph);
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy, input logic [1:0] rsp,
                         input logic [N-1:0] spl);
        hbusreq = req; hlock = lck; htrans = tr; hburst = bu;
        hready  = rdy; hresp = rsp; hsplit = spl;
    endtask

    task automatic apply_reset(input string ph);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq({ph, "/rst_gnt_fp"}, 32'(gnt_fp), 32'(3'b001));
        check_eq({ph, "/rst_gnt_rr"}, 32'(gnt_rr), 32'(3'b001));
        check_eq({ph, "/rst_mst"},    32'({mst_fp, mst_rr}), 32'(0));
        check_eq({ph, "/rst_del"},    32'({del_fp, del_rr}), 32'(0));
        check_eq({ph, "/rst_lck"},    32'({mlk_fp, mlk_rr}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(3'b000, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        #2;

        // Fixed priority, masters 1 and 2 requesting.
        apply_reset("fp110");
        drive(3'b110, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("fp110");
        check_eq("fp110_gnt", 32'(gnt_fp), 32'(3'b010));
        step("fp110");
        check_eq("fp110_mst", 32'(mst_fp), 32'(1));

        // Round robin over consecutive SINGLE transfers.
        apply_reset("rr");
        drive(3'b111, 3'b000, 2'b10, 3'd0, 1'b1, 2'b00, 3'b000);
        step("rr"); check_eq("rr_gnt1", 32'(gnt_rr), 32'(3'b010));
        step("rr"); check_eq("rr_gnt2", 32'(gnt_rr), 32'(3'b100));
        step("rr"); check_eq("rr_gnt0", 32'(gnt_rr), 32'(3'b001));

        // M2 INCR8 with M0 requesting, three wait states in the middle.
        apply_reset("incr8");
        drive(3'b100, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("incr8"); step("incr8");
        check_eq("incr8_owner", 32'(mst_fp), 32'(2));
        drive(3'b101, 3'b000, 2'b10, 3'd5, 1'b1, 2'b00, 3'b000);
        step("incr8");
        check_eq("incr8_first", 32'(gnt_fp), 32'(3'b100));
        for (int b = 1; b <= 7; b++) begin
            if (b == 4) begin
                drive(3'b101, 3'b000, 2'b11, 3'd5, 1'b0, 2'b00, 3'b000);
                for (int w = 0; w < 3; w++) begin
                    step("wait");
                    check_eq("wait_mst", 32'(mst_fp), 32'(2));
                    check_eq("wait_del", 32'(del_fp), 32'(2));
                    check_eq("wait_gnt", 32'(gnt_fp), 32'(3'b100));
                end
            end
            drive(3'b101, 3'b000, 2'b11, 3'd5, 1'b1, 2'b00, 3'b000);
            step("incr8");
            check_eq("incr8_beat", 32'(gnt_fp), (b == 7) ? 32'(3'b001) : 32'(3'b100));
        end

        // Locked INCR4 plus SINGLE by M1 keeps M0 out until the lock drops.
        apply_reset("lock");
        drive(3'b010, 3'b010, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("lock"); step("lock");
        check_eq("lock_mlk", 32'(mlk_fp), 32'(1));
        drive(3'b011, 3'b010, 2'b10, 3'd3, 1'b1, 2'b00, 3'b000);
        step("lock");
        for (int s = 0; s < 3; s++) begin
            drive(3'b011, 3'b010, 2'b11, 3'd3, 1'b1, 2'b00, 3'b000);
            step("lock");
            check_eq("lock_burst", 32'(gnt_fp), 32'(3'b010));
        end
        drive(3'b011, 3'b010, 2'b10, 3'd0, 1'b1, 2'b00, 3'b000);
        step("lock"); check_eq("lock_single", 32'(gnt_fp), 32'(3'b010));
        drive(3'b011, 3'b010, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("lock"); check_eq("lock_idle", 32'(gnt_fp), 32'(3'b010));
        drive(3'b011, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("lock"); check_eq("lock_release", 32'(gnt_fp), 32'(3'b001));

        // SPLIT to M1, unsplit, then simultaneous set and clear.
        apply_reset("split");
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("split"); step("split"); step("split");
        check_eq("split_del", 32'(del_fp), 32'(1));
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b0, 2'b11, 3'b000);
        step("split"); check_eq("split_c1", 32'(gnt_fp), 32'(3'b001));
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b1, 2'b11, 3'b000);
        step("split"); check_eq("split_c2", 32'(gnt_fp), 32'(3'b001));
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("split"); check_eq("split_masked", 32'(gnt_fp), 32'(3'b001));
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b010);
        step("split");
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("split"); check_eq("split_unmask", 32'(gnt_fp), 32'(3'b010));
        step("split"); step("split");
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b0, 2'b11, 3'b010);
        step("split");
        drive(3'b010, 3'b000, 2'b00, 3'd0, 1'b1, 2'b00, 3'b000);
        step("split"); check_eq("split_setwins", 32'(gnt_fp), 32'(3'b001));

        // Random traffic with occasional asynchronous reset.
        for (int c = 0; c < 4000; c++) begin
            int r;
            hbusreq = 3'($urandom);
            hlock   = ($urandom_range(0, 3) == 0) ? (3'($urandom) & hbusreq) : 3'b000;
            r = $urandom_range(0, 9);
            htrans  = (r < 2) ? 2'b00 : (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            if (htrans == 2'b10) hburst = 3'($urandom);
            hready  = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            hresp   = hready ? 2'b00 : (r < 3) ? 2'b11 : (r < 5) ? 2'b10 : (r < 6) ? 2'b01 : 2'b00;
            hsplit  = ($urandom_range(0, 7) == 0) ? 3'(3'b001 << $urandom_range(0, 2)) : 3'b000;
            step("rand");
            if ($urandom_range(0, 499) == 0) apply_reset("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
